// File: rtl/ascon_uart_ctrl.sv
// Byte-level command sequencer between the UART RX/TX byte streams and the
// Ascon AEAD core. It assembles key/nonce/AD/plaintext from received bytes,
// fires the core under a watchdog, then streams cipher+tag (or an 0xEE error
// byte) back out on the TX valid/ready interface.
module ascon_uart_ctrl #(
  parameter int WAVE_BYTES  = 184,
  parameter int KEY_BYTES   = 16,
  parameter int NONCE_BYTES = 16,
  parameter int DA_BYTES    = 8,
  parameter int TIMEOUT     = 65535
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [8*KEY_BYTES-1:0]    key_o,
  output logic [8*NONCE_BYTES-1:0]  nonce_o,
  output logic [8*DA_BYTES-1:0]     da_o,
  output logic [8*WAVE_BYTES-1:0]   plain_text_o,
  output logic                      start_o,
  input  logic                      done_i,
  input  logic [8*WAVE_BYTES-1:0]   cipher_i,
  input  logic [127:0]              tag_i,
  output logic                      busy_o
);
  localparam int KW        = 8*KEY_BYTES;
  localparam int NW        = 8*NONCE_BYTES;
  localparam int DW        = 8*DA_BYTES;
  localparam int FW        = 8*WAVE_BYTES;
  localparam int SW        = FW + 128;
  localparam int OUT_BYTES = WAVE_BYTES + 16;
  localparam int CW        = $clog2(OUT_BYTES + 1);
  localparam int WW        = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_KEY, LOAD_NONCE, LOAD_DA, LOAD_WAVE, START, WAIT, SEND, SEND_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic [SW-1:0] sr;
  logic [CW-1:0] load_last;
  logic          in_load;
  logic          wd_expire;
  logic          tx_last;

  // The watchdog hits TIMEOUT on the increment made in this cycle.
  assign wd_expire = (wd == WW'(TIMEOUT - 1));
  assign tx_last   = (cnt == CW'(OUT_BYTES - 1));
  assign tx_data_o = sr[SW-1 -: 8];

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and state-derived outputs (no path from tx_ready_i to tx_valid_o).
  always_comb begin
    state_nxt  = state;
    start_o    = 1'b0;
    tx_valid_o = 1'b0;
    busy_o     = (state != IDLE);
    load_last  = '0;
    in_load    = 1'b0;
    case (state)
      IDLE: if (rx_valid_i) begin
        case (rx_data_i)
          8'h4B:   state_nxt = LOAD_KEY;
          8'h4E:   state_nxt = LOAD_NONCE;
          8'h41:   state_nxt = LOAD_DA;
          8'h57:   state_nxt = LOAD_WAVE;
          8'h47:   state_nxt = START;
          default: state_nxt = IDLE;
        endcase
      end
      LOAD_KEY:   begin in_load = 1'b1; load_last = CW'(KEY_BYTES - 1);   end
      LOAD_NONCE: begin in_load = 1'b1; load_last = CW'(NONCE_BYTES - 1); end
      LOAD_DA:    begin in_load = 1'b1; load_last = CW'(DA_BYTES - 1);    end
      LOAD_WAVE:  begin in_load = 1'b1; load_last = CW'(WAVE_BYTES - 1);  end
      START: begin
        start_o   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done_i takes priority over a simultaneous watchdog expiry.
        if (done_i)         state_nxt = SEND;
        else if (wd_expire) state_nxt = SEND_ERR;
      end
      SEND: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i && tx_last) state_nxt = IDLE;
      end
      SEND_ERR: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (in_load && rx_valid_i && (cnt == load_last)) state_nxt = IDLE;
  end

  // Datapath: byte loaders, watchdog, byte counter and the TX shift register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      key_o        <= '0;
      nonce_o      <= '0;
      da_o         <= '0;
      plain_text_o <= '0;
      cnt          <= '0;
      wd           <= '0;
      sr           <= '0;
    end else begin
      if (in_load && rx_valid_i)
        cnt <= (cnt == load_last) ? '0 : cnt + CW'(1);
      case (state)
        LOAD_KEY:   if (rx_valid_i) key_o        <= {key_o[KW-9:0], rx_data_i};
        LOAD_NONCE: if (rx_valid_i) nonce_o      <= {nonce_o[NW-9:0], rx_data_i};
        LOAD_DA:    if (rx_valid_i) da_o         <= {da_o[DW-9:0], rx_data_i};
        LOAD_WAVE:  if (rx_valid_i) plain_text_o <= {plain_text_o[FW-9:0], rx_data_i};
        START:      wd <= '0;
        WAIT: begin
          wd <= wd + WW'(1);
          if (done_i)         sr <= {cipher_i, tag_i};
          else if (wd_expire) sr <= {8'hEE, {(SW-8){1'b0}}};
        end
        SEND: if (tx_ready_i) begin
          sr  <= {sr[SW-9:0], 8'h00};
          cnt <= tx_last ? '0 : cnt + CW'(1);
        end
        SEND_ERR: if (tx_ready_i) sr <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_uart_ctrl.sv
// Self-checking bench for ascon_uart_ctrl: random byte loads and cipher/tag
// frames compared against a byte-position model, with random TX backpressure.
module tb_ascon_uart_ctrl;
  localparam int WB = 184;
  localparam int FW = 8*WB;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [127:0]  key, nonce;
  logic [63:0]   da;
  logic [FW-1:0] plain;
  logic          start;
  logic          done;
  logic [FW-1:0] cipher;
  logic [127:0]  tag;
  logic          busy;

  int vecs = 0;
  int errs = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];

  ascon_uart_ctrl #(.WAVE_BYTES(WB), .KEY_BYTES(16), .NONCE_BYTES(16),
                    .DA_BYTES(8), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .key_o(key), .nonce_o(nonce), .da_o(da), .plain_text_o(plain),
    .start_o(start), .done_i(done), .cipher_i(cipher), .tag_i(tag), .busy_o(busy));

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // Called at a negedge; the byte is consumed at the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  // Random cipher frame and fixed tag; expected TX order is cipher MSB-first, then tag.
  task automatic build_frame();
    for (int i = 0; i < WB; i++) cipher[8*i +: 8] = 8'($urandom);
    tag = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    exp_q.delete();
    for (int i = 0; i < WB; i++) exp_q.push_back(cipher[FW-1-8*i -: 8]);
    for (int i = 0; i < 16; i++) exp_q.push_back(tag[127-8*i -: 8]);
  endtask

  // Collect the TX stream with random backpressure and compare it to exp_q.
  task automatic drain(input int low_pct);
    logic [7:0] got_q[$];
    logic       hold = 1'b0;
    logic [7:0] hd = 8'h00;
    int         cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 5000) begin
      if (tx_valid !== 1'b1) begin
        errs++; vecs++;
        $display("FAIL tx_valid_drop: got %b want 1 after %0d bytes", tx_valid, got_q.size());
        break;
      end
      if (hold) begin
        vecs++;
        if (tx_data !== hd) begin
          errs++;
          $display("FAIL tx_stall_stable: got %h want %h", tx_data, hd);
        end
      end
      tx_ready = ($urandom_range(99) >= low_pct);
      if (tx_ready) begin got_q.push_back(tx_data); hold = 1'b0; end
      else          begin hold = 1'b1; hd = tx_data; end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    vecs++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL send_end: busy=%b tx_valid=%b want 0 0", busy, tx_valid);
    end
    vecs++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL tx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (got_q[i] !== exp_q[i]) begin
        errs++;
        $display("FAIL tx_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (key !== '0 || nonce !== '0 || da !== '0 || plain !== '0 ||
        start !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_state: busy=%b tx_valid=%b start=%b key=%h", busy, tx_valid, start, key);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    logic [127:0] km = '0;
    send_byte(8'h4B);
    repeat (5) send_byte(8'($urandom));
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL midload_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (key !== '0 || busy !== 1'b0) begin
      errs++; $display("FAIL async_reset: key=%h busy=%b want 0 0", key, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h4B);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b = 8'($urandom);
      km[127-8*i -: 8] = b;
      send_byte(b);
    end
    vecs++;
    if (key !== km || busy !== 1'b0) begin
      errs++; $display("FAIL reload_key: got %h busy=%b want %h 0", key, busy, km);
    end
  endtask

  task automatic test_key_order();
    logic [127:0] nm = '0;
    logic [7:0]   b;
    send_byte(8'h4B);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      if (i == 14) begin
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL key_busy: got %b want 1", busy); end
      end
    end
    vecs++;
    if (key !== 128'h000102030405060708090A0B0C0D0E0F || busy !== 1'b0) begin
      errs++; $display("FAIL key_order: got %h busy=%b", key, busy);
    end
    send_byte(8'h4E);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom); nm[127-8*i -: 8] = b; send_byte(b);
    end
    vecs++;
    if (nonce !== nm || busy !== 1'b0) begin
      errs++; $display("FAIL nonce_order: got %h want %h", nonce, nm);
    end
    send_byte(8'h41);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    vecs++;
    if (da !== 64'hA0A1A2A3A4A5A6A7 || busy !== 1'b0) begin
      errs++; $display("FAIL da_order: got %h want a0a1a2a3a4a5a6a7", da);
    end
    vecs++;
    if (key !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errs++; $display("FAIL key_hold: got %h", key);
    end
    send_byte(8'h5A);   // unknown command: stays idle
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL bad_cmd: busy=%b want 0", busy); end
  endtask

  task automatic test_wave();
    logic [FW-1:0] pm = '0;
    logic [7:0]    b, b0;
    int            s0 = start_cnt;
    send_byte(8'h57);
    for (int i = 0; i < WB; i++) begin
      case (i)
        WB-4:    b = 8'h52;
        WB-3:    b = 8'h80;
        WB-2,
        WB-1:    b = 8'h00;
        default: b = 8'($urandom);
      endcase
      if (i == 0) b0 = b;
      pm[FW-1-8*i -: 8] = b;
      send_byte(b);
    end
    vecs++;
    if (plain !== pm) begin errs++; $display("FAIL wave_frame: top=%h want %h", plain[FW-1 -: 32], pm[FW-1 -: 32]); end
    vecs++;
    if (plain[23:0] !== 24'h800000 || plain[FW-1 -: 8] !== b0) begin
      errs++; $display("FAIL wave_ends: low=%h first=%h want 800000 %h", plain[23:0], plain[FW-1 -: 8], b0);
    end
    vecs++;
    if (start_cnt != s0 || busy !== 1'b0) begin
      errs++; $display("FAIL wave_nostart: starts=%0d busy=%b want 0 0", start_cnt - s0, busy);
    end
  endtask

  task automatic test_go(input int low_pct);
    int s0 = start_cnt;
    build_frame();
    send_byte(8'h47);
    vecs++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL start_latency: start=%b busy=%b want 1 1", start, busy);
    end
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (start !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b1) begin
        errs++; vecs++;
        $display("FAIL wait_quiet: start=%b tx_valid=%b busy=%b want 0 0 1", start, tx_valid, busy);
        break;
      end
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cipher = ~cipher;   // snapshot must be independent of later cipher_i
    tag = '0;
    vecs++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      errs++; $display("FAIL done_latency: tx_valid=%b data=%h want 1 %h", tx_valid, tx_data, exp_q[0]);
    end
    drain(low_pct);
    vecs++;
    if (start_cnt - s0 != 1) begin errs++; $display("FAIL start_once: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    logic [127:0] k0 = key;
    int cyc = 0;
    send_byte(8'h47);
    vecs++;
    if (start !== 1'b1) begin errs++; $display("FAIL to_start: got %b want 1", start); end
    @(negedge clk);     // first WAIT cycle
    while (tx_valid !== 1'b1 && cyc < 1000) begin
      cyc++;
      rx_valid = (cyc == 20 || cyc == 21);
      rx_data  = (cyc == 20) ? 8'h58 : 8'h4B;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    vecs++;
    if (cyc != TO) begin errs++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TO); end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
        errs++; $display("FAIL err_byte: valid=%b data=%h want 1 ee", tx_valid, tx_data);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    vecs++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || key !== k0) begin
      errs++; $display("FAIL err_done: valid=%b busy=%b key_ok=%b", tx_valid, busy, key === k0);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL late_done: valid=%b busy=%b want 0 0", tx_valid, busy);
    end
  endtask

  // done_i in the very cycle the watchdog expires must still produce the frame.
  task automatic test_done_tie();
    build_frame();
    send_byte(8'h47);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    vecs++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      errs++; $display("FAIL done_tie: valid=%b data=%h want 1 %h", tx_valid, tx_data, exp_q[0]);
    end
    drain(10);
  endtask

  initial begin
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; done = 1'b0;
    cipher = '0; tag = '0;
    test_reset();
    test_reset_mid_load();
    test_key_order();
    test_wave();
    test_go(0);
    test_go(30);
    test_timeout();
    test_done_tie();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
